// File: rtl/bram_sdp_fifo.sv
// Single-clock FIFO on an inferred simple-dual-port block RAM, arbitrary depth,
// optional output register, occupancy flags and sticky overflow/underflow.
module bram_sdp_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 60,
    parameter int OUT_REG   = 0,
    parameter int AFULL_LVL = DEPTH - 4,
    parameter int AW        = $clog2(DEPTH),
    parameter int CW        = $clog2(DEPTH + 1)
) (
    input  logic             clka,
    input  logic             rsta,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic [CW-1:0]    count,
    input  logic             clr_err,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_LVL);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_acc;
    logic             rd_acc;
    logic [WIDTH-1:0] data_p1;
    logic             vld_p1;

    // Pointers wrap at DEPTH-1 explicitly so non-power-of-two depths work.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + AW'(1);
    endfunction

    assign full        = (count == DEPTH_C);
    assign empty       = (count == '0);
    assign almost_full = (count >= AFULL_C);
    assign wr_acc      = wr_en & ~full;
    assign rd_acc      = rd_en & ~empty;

    always_ff @(posedge clka) begin
        if (wr_acc) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clka or negedge rsta) begin
        if (!rsta) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
            if (wr_acc && !rd_acc)      count <= count + CW'(1);
            else if (rd_acc && !wr_acc) count <= count - CW'(1);
        end
    end

    // A new error in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clka or negedge rsta) begin
        if (!rsta) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full) overflow <= 1'b1;
            else if (clr_err)  overflow <= 1'b0;
            if (rd_en && empty) underflow <= 1'b1;
            else if (clr_err)   underflow <= 1'b0;
        end
    end

    // Stage p1: BRAM read register
    always_ff @(posedge clka or negedge rsta) begin
        if (!rsta) begin
            data_p1 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= rd_acc;
            if (rd_acc) data_p1 <= mem[rd_ptr];
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [WIDTH-1:0] data_p2;
            logic             vld_p2;

            // Stage p2: optional output register
            always_ff @(posedge clka or negedge rsta) begin
                if (!rsta) begin
                    data_p2 <= '0;
                    vld_p2  <= 1'b0;
                end else begin
                    vld_p2 <= vld_p1;
                    if (vld_p1) data_p2 <= data_p1;
                end
            end

            assign rd_data  = data_p2;
            assign rd_valid = vld_p2;
        end else begin : g_noreg
            assign rd_data  = data_p1;
            assign rd_valid = vld_p1;
        end
    endgenerate

endmodule

// File: tb/tb_bram_sdp_fifo.sv
// Randomized bench for bram_sdp_fifo: two instances (OUT_REG 0 and 1) share stimulus
// and are checked every cycle against a queue-based reference model.
module tb_bram_sdp_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 60;
    localparam int AFL   = DEPTH - 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clka = 1'b0;
    logic             rsta = 1'b0;
    logic             wr_en = 1'b0;
    logic             rd_en = 1'b0;
    logic             clr_err = 1'b0;
    logic [WIDTH-1:0] wr_data = '0;

    logic [WIDTH-1:0] rd_data0, rd_data1;
    logic             rd_valid0, rd_valid1;
    logic             full0, full1, empty0, empty1, af0, af1;
    logic [CW-1:0]    count0, count1;
    logic             ovf0, ovf1, unf0, unf1;

    bram_sdp_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .OUT_REG(0)) u_fifo0 (
        .clka(clka), .rsta(rsta), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data0), .rd_valid(rd_valid0), .full(full0), .empty(empty0),
        .almost_full(af0), .count(count0), .clr_err(clr_err),
        .overflow(ovf0), .underflow(unf0)
    );

    bram_sdp_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .OUT_REG(1)) u_fifo1 (
        .clka(clka), .rsta(rsta), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data1), .rd_valid(rd_valid1), .full(full1), .empty(empty1),
        .almost_full(af1), .count(count1), .clr_err(clr_err),
        .overflow(ovf1), .underflow(unf1)
    );

    always #5 clka = ~clka;

    int checks = 0;
    int errors = 0;

    // Reference model: stored words, sticky flags, expected output after 1 and 2 cycles.
    logic [WIDTH-1:0] q[$];
    logic             m_ovf, m_unf;
    logic             e1_v, e2_v;
    logic [WIDTH-1:0] e1_d, e2_d;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        e1_v  = 1'b0;
        e2_v  = 1'b0;
        e1_d  = '0;
        e2_d  = '0;
    endtask

    task automatic model_edge(input logic wr, input logic [WIDTH-1:0] wd,
                              input logic rd, input logic clr);
        bit was_full, was_empty, wacc, racc;
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        wacc = wr && !was_full;
        racc = rd && !was_empty;
        e2_v = e1_v;
        if (e1_v) e2_d = e1_d;
        e1_v = racc;
        if (racc) e1_d = q.pop_front();
        if (wacc) q.push_back(wd);
        if (wr && was_full) m_ovf = 1'b1;
        else if (clr)       m_ovf = 1'b0;
        if (rd && was_empty) m_unf = 1'b1;
        else if (clr)        m_unf = 1'b0;
    endtask

    task automatic compare_all();
        int n;
        n = q.size();
        chk("count0", 32'(count0), 32'(n));
        chk("count1", 32'(count1), 32'(n));
        chk("empty", 32'(empty0), 32'(n == 0));
        chk("full", 32'(full0), 32'(n == DEPTH));
        chk("almost_full", 32'(af0), 32'(n >= AFL));
        chk("flags1", {29'b0, full1, empty1, af1}, {29'b0, full0 == 1'b1 ? 1'b0 : 1'b0, 2'b0} | 32'({n == DEPTH, n == 0, n >= AFL}));
        chk("overflow", 32'({ovf1, ovf0}), 32'({m_ovf, m_ovf}));
        chk("underflow", 32'({unf1, unf0}), 32'({m_unf, m_unf}));
        chk("rd_valid0", 32'(rd_valid0), 32'(e1_v));
        chk("rd_data0", 32'(rd_data0), 32'(e1_d));
        chk("rd_valid1", 32'(rd_valid1), 32'(e2_v));
        chk("rd_data1", 32'(rd_data1), 32'(e2_d));
    endtask

    // One clock: drive, let both DUTs and the model take the edge, then compare.
    task automatic step(input logic wr, input logic [WIDTH-1:0] wd,
                        input logic rd, input logic clr);
        wr_en   = wr;
        wr_data = wd;
        rd_en   = rd;
        clr_err = clr;
        @(posedge clka);
        if (rsta) model_edge(wr, wd, rd, clr);
        else      model_reset();
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input int cycles);
        rsta = 1'b0;
        model_reset();
        #1;
        chk("rst_async_valid", 32'({rd_valid1, rd_valid0}), 32'd0);
        chk("rst_async_count", 32'(count0), 32'd0);
        for (int i = 0; i < cycles; i++) step(1'b0, '0, 1'b0, 1'b0);
        rsta = 1'b1;
    endtask

    initial begin
        model_reset();

        // Reset
        do_reset(5);
        #1;
        chk("rst_empty", 32'(empty0), 32'd1);
        chk("rst_full", 32'(full0), 32'd0);
        chk("rst_af", 32'(af0), 32'd0);
        chk("rst_err", 32'({ovf0, unf0}), 32'd0);
        idle(1);

        // Fill with 3,5,...,121
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, WIDTH'(3 + 2 * i), 1'b0, 1'b0);
            if (i == AFL - 2) chk("af_below", 32'(af0), 32'd0);
            if (i == AFL - 1) chk("af_at_lvl", 32'(af0), 32'd1);
        end
        chk("fill_full", 32'(full0), 32'd1);
        step(1'b1, 8'd123, 1'b0, 1'b0);
        chk("ovf_write", 32'(ovf0), 32'd1);
        chk("ovf_count", 32'(count0), 32'(DEPTH));
        step(1'b1, 8'h55, 1'b0, 1'b1);
        chk("ovf_set_wins", 32'(ovf0), 32'd1);

        // Drain back-to-back; stored data must be the original fill
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            chk("drain_v0", 32'(rd_valid0), 32'd1);
            chk("drain_d0", 32'(rd_data0), 32'(3 + 2 * i));
            if (i > 0) begin
                chk("drain_v1", 32'(rd_valid1), 32'd1);
                chk("drain_d1", 32'(rd_data1), 32'(3 + 2 * (i - 1)));
            end
        end
        chk("drain_empty", 32'(empty0), 32'd1);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("drain_last_d1", 32'(rd_data1), 32'd121);
        chk("unf_read", 32'(unf0), 32'd1);
        chk("unf_no_valid", 32'(rd_valid0), 32'd0);
        idle(2);

        // Clearing errors, including with nothing pending
        step(1'b0, '0, 1'b0, 1'b1);
        chk("clr_err", 32'({ovf0, unf0}), 32'd0);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("clr_noerr", 32'({ovf0, unf0}), 32'd0);

        // Simultaneous read and write while empty
        step(1'b1, 8'hA5, 1'b1, 1'b0);
        chk("empty_rw_count", 32'(count0), 32'd1);
        chk("empty_rw_unf", 32'(unf0), 32'd1);
        step(1'b0, '0, 1'b1, 1'b1);
        idle(2);

        // Simultaneous read and write while full
        for (int i = 0; i < DEPTH; i++) step(1'b1, WIDTH'($urandom), 1'b0, 1'b0);
        step(1'b1, WIDTH'($urandom), 1'b1, 1'b0);
        chk("full_rw_count", 32'(count0), 32'(DEPTH - 1));
        chk("full_rw_ovf", 32'(ovf0), 32'd1);
        idle(2);

        // Pointer wrap from a known origin
        do_reset(2);
        idle(1);
        for (int i = 0; i < 50; i++) step(1'b1, WIDTH'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 50; i++) step(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, WIDTH'(200 + i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            chk("wrap_d0", 32'(rd_data0), 32'(200 + i));
        end
        idle(2);
        chk("wrap_count", 32'(count0), 32'd0);

        // Concurrent streaming at constant occupancy
        for (int i = 0; i < 30; i++) step(1'b1, WIDTH'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) begin
            step(1'b1, WIDTH'($urandom), 1'b1, 1'b0);
            chk("conc_count", 32'(count0), 32'd30);
        end

        // Random traffic, write-biased then read-biased
        for (int i = 0; i < 3000; i++) begin
            int wp;
            wp = (i < 1500) ? 65 : 35;
            step(($urandom_range(0, 99) < wp), WIDTH'($urandom),
                 ($urandom_range(0, 99) < 100 - wp), ($urandom_range(0, 99) < 5));
        end

        // Reset dropped in the middle of a read burst
        do_reset(1);
        idle(1);
        for (int i = 0; i < 10; i++) step(1'b1, WIDTH'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
        rsta = 1'b0;
        model_reset();
        #1;
        chk("midrst_valid", 32'({rd_valid1, rd_valid0}), 32'd0);
        chk("midrst_count", 32'(count0), 32'd0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
        rsta = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b0, 1'b0);
            chk("postrst_valid", 32'({rd_valid1, rd_valid0}), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
